// File: rtl/fxp_pkg.sv
// Shared types and helpers for the sign-magnitude fixed-point ALU.
// Word layout: bit N-1 is the sign, the remaining bits are the magnitude with Q fraction bits.
package fxp_pkg;

    localparam int FXP_N = 32;
    localparam int FXP_Q = 15;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    function automatic logic [FXP_N-1:0] sat_val(input logic sign);
        return {sign, {(FXP_N-1){1'b1}}};
    endfunction

    // Shifting out the sign bit leaves only the magnitude to test.
    function automatic logic is_zero_mag(input logic [FXP_N-1:0] word);
        return (word << 1) == '0;
    endfunction

endpackage

// File: rtl/fxp_div_iter.sv
// Restoring divider datapath: one quotient bit per step over M+Q steps.
// Exposes the quotient as it will be after the current step so the last step can be captured directly.
module fxp_div_iter
    import fxp_pkg::*;
#(
    parameter int M = FXP_N - 1,
    parameter int Q = FXP_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [M-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic [M-1:0] quot_mag,
    output logic         quot_ovf
);
    localparam int D = M + Q;

    logic [M-1:0] rem;
    logic [M-1:0] dvsr;
    logic [D-1:0] q;
    logic [M:0]   trial;
    logic         fits;
    logic [M-1:0] rem_nxt;
    logic [D-1:0] q_nxt;

    // q starts as the pre-shifted dividend; dividend bits leave at the top as quotient bits enter at the bottom.
    always_comb begin
        trial    = {rem, q[D-1]};
        fits     = trial >= {1'b0, dvsr};
        rem_nxt  = M'(trial - (fits ? {1'b0, dvsr} : {(M+1){1'b0}}));
        q_nxt    = {q[D-2:0], fits};
        quot_mag = q_nxt[M-1:0];
        quot_ovf = |q_nxt[D-1:M];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            dvsr <= '0;
            q    <= '0;
        end else if (load) begin
            rem  <= '0;
            dvsr <= divisor;
            q    <= {dividend, {Q{1'b0}}};
        end else if (step) begin
            rem  <= rem_nxt;
            q    <= q_nxt;
        end
    end

endmodule

// File: rtl/fxp_seq_alu.sv
// Multi-cycle sign-magnitude fixed-point ALU: single-cycle add/sub,
// iterative shift-add multiply and restoring divide, saturating on overflow.
module fxp_seq_alu
    import fxp_pkg::*;
#(
    parameter int N = FXP_N,
    parameter int Q = FXP_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   opcode,
    output logic [N-1:0] c,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         dz
);
    localparam int M  = N - 1;
    localparam int CW = $clog2(M + Q + 1);

    state_t        state, state_nxt;
    opcode_t       op;
    logic [CW-1:0] cnt;
    logic          accept, b_zero, last_mul, last_div, res_sign;
    logic          sb_eff, add_sign, add_ovf;
    logic [M:0]    add_sum;
    logic [M-1:0]  add_mag;
    logic [M-1:0]  mcand;
    logic [2*M-1:0] prod, prod_nxt;
    logic [M:0]    mul_sum;
    logic [M-1:0]  mul_mag, div_mag;
    logic          mul_ovf, div_ovf;

    function automatic logic [N-1:0] pack_result(input logic sign, input logic [M-1:0] mag,
                                                 input logic sat);
        logic [N-1:0] w;
        w = sat ? N'(sat_val(sign)) : {sign, mag};
        if (is_zero_mag(w))
            w[N-1] = 1'b0;
        return w;
    endfunction

    assign op       = opcode_t'(opcode);
    assign b_zero   = is_zero_mag(b);
    assign accept   = start && !busy;
    assign last_mul = (state == S_MUL) && (cnt == CW'(M - 1));
    assign last_div = (state == S_DIV) && (cnt == CW'(M + Q - 1));

    // Subtraction is addition with the sign of b flipped; unequal signs take the larger magnitude's sign.
    always_comb begin
        sb_eff   = b[N-1] ^ (op == OP_SUB);
        add_sum  = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
        add_sign = a[N-1];
        add_mag  = add_sum[M-1:0];
        add_ovf  = 1'b0;
        if (a[N-1] != sb_eff) begin
            if (a[M-1:0] >= b[M-1:0]) begin
                add_mag = a[M-1:0] - b[M-1:0];
            end else begin
                add_mag  = b[M-1:0] - a[M-1:0];
                add_sign = sb_eff;
            end
        end else begin
            add_ovf = add_sum[M];
        end
    end

    // Right-shifting shift-add: the multiplier sits in the low half and is consumed one bit per step.
    always_comb begin
        mul_sum  = {1'b0, prod[2*M-1:M]} + {1'b0, (prod[0] ? mcand : {M{1'b0}})};
        prod_nxt = {mul_sum, prod[M-1:1]};
        mul_ovf  = |prod_nxt[2*M-1:M+Q];
        mul_mag  = prod_nxt[M+Q-1:Q];
    end

    fxp_div_iter #(.M(M), .Q(Q)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && (op == OP_DIV)),
        .step     (state == S_DIV),
        .dividend (a[M-1:0]),
        .divisor  (b[M-1:0]),
        .quot_mag (div_mag),
        .quot_ovf (div_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    case (op)
                        OP_MUL:  state_nxt = S_MUL;
                        OP_DIV:  state_nxt = b_zero ? S_DONE : S_DIV;
                        default: state_nxt = S_DONE;
                    endcase
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (last_mul)
                    state_nxt = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (last_div)
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results are captured on the edge entering DONE and held until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            c        <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
            mcand    <= '0;
            prod     <= '0;
            res_sign <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            res_sign <= a[N-1] ^ b[N-1];
            mcand    <= a[M-1:0];
            prod     <= {{M{1'b0}}, b[M-1:0]};
            if (op == OP_ADD || op == OP_SUB) begin
                c   <= pack_result(add_sign, add_mag, add_ovf);
                ovf <= add_ovf;
                dz  <= 1'b0;
            end else if (op == OP_DIV && b_zero) begin
                c   <= pack_result(a[N-1] ^ b[N-1], {M{1'b0}}, 1'b1);
                ovf <= 1'b0;
                dz  <= 1'b1;
            end
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (state == S_MUL)
                prod <= prod_nxt;
            if (last_mul) begin
                c   <= pack_result(res_sign, mul_mag, mul_ovf);
                ovf <= mul_ovf;
                dz  <= 1'b0;
            end
            if (last_div) begin
                c   <= pack_result(res_sign, div_mag, div_ovf);
                ovf <= div_ovf;
                dz  <= 1'b0;
            end
        end
    end

endmodule
